// File: rtl/period_meter_pkg.sv
// Shared types and default parameters for the period meter.
package period_meter_pkg;

  localparam int unsigned WIDTH_DEF       = 24;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned TIMEOUT_DEF     = 12000000;

  typedef enum logic [0:0] {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_e;

endpackage

// File: rtl/period_meter_if.sv
// Control and result bundle between the period meter and its user.
interface period_meter_if
  import period_meter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) ();

  logic             en;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             active;

  modport master (
    output en, sig_in,
    input  period, high_time, meas_valid, timeout, active
  );

  modport slave (
    input  en, sig_in,
    output period, high_time, meas_valid, timeout, active
  );

endinterface

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous level and flags its rising edges.
// The rise strobe is registered and only raised once the delayed-level flop
// holds a real sample, so an input already high out of reset is not an edge.
module edge_sync
  import period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   vld_q;
  logic                   lvl_d_q;
  logic                   rise_q;

  // Synchronizer chain, sample-valid tracker and registered edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      vld_q   <= '0;
      lvl_d_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_async};
      vld_q   <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      lvl_d_q <= sync_q[SYNC_STAGES-1];
      rise_q  <= sync_q[SYNC_STAGES-1] & ~lvl_d_q & vld_q[SYNC_STAGES];
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = rise_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  period_meter_if.slave bus
);

  logic             lvl;
  logic             rise;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic             active_q;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (bus.sig_in),
    .lvl     (lvl),
    .rise    (rise)
  );

  // Next state: enable overrides everything, a rise beats the timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    tmo_d    = 1'b0;

    if (!bus.en) begin
      state_d = WAIT_EDGE;
      cnt_d   = '0;
      hi_d    = '0;
    end else begin
      case (state_q)
        WAIT_EDGE: begin
          cnt_d = '0;
          hi_d  = '0;
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = WIDTH'(1);
            hi_d    = WIDTH'(1);
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hi_q;
            valid_d  = 1'b1;
            cnt_d    = WIDTH'(1);
            hi_d     = WIDTH'(1);
          end else if (cnt_q == WIDTH'(TIMEOUT)) begin
            tmo_d   = 1'b1;
            state_d = WAIT_EDGE;
            cnt_d   = '0;
            hi_d    = '0;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
            hi_d  = hi_q + WIDTH'(lvl);
          end
        end
        default: begin
          state_d = WAIT_EDGE;
          cnt_d   = '0;
          hi_d    = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= WAIT_EDGE;
      cnt_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
      active_q <= (state_d == MEASURE);
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = valid_q;
  assign bus.timeout    = tmo_q;
  assign bus.active     = active_q;

endmodule
